// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for a VGA-style display. Two free-running counters
//   walk every pixel of an H_TOTAL x V_TOTAL frame. Sync and blanking flags are
//   decoded from the counter values and registered together with them. A
//   one-cycle frame_start pulse marks the return to pixel (0,0) at the end of
//   each frame.
//
// Ports:
//   pclk        in   1   pixel clock; every state change happens on its rising edge
//   rst         in   1   synchronous, active-high reset
//   hcount_out  out  11  horizontal pixel counter, 0 .. H_TOTAL-1
//   vcount_out  out  11  vertical line counter,    0 .. V_TOTAL-1
//   hsync_out   out  1   horizontal sync (active-high)
//   vsync_out   out  1   vertical sync (active-high)
//   hblnk_out   out  1   horizontal blanking (hcount_out >= H_VISIBLE)
//   vblnk_out   out  1   vertical blanking   (vcount_out >= V_VISIBLE)
//   frame_start out  1   one-cycle pulse when the outputs show (0,0) after a
//                        frame wrap; never set while in reset
//
// Every output is a flip-flop Q, and all outputs describe the same pixel in
// the same cycle: the flags are decoded from the *next* counter values, so
// they add no latency relative to the counters.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        frame_start
);

    // -------------------------------------------------------------------------
    // Derived timing constants
    // -------------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Last legal counter value. Totals are at most 2048, so these fit 11 bits.
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Window boundaries are held in 12 bits: a sync window may end exactly at
    // 2048, which does not fit in the 11-bit counter width.
    localparam logic [11:0] H_BLANK_START = 12'(H_VISIBLE);
    localparam logic [11:0] H_SYNC_START  = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] H_SYNC_STOP   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_BLANK_START = 12'(V_VISIBLE);
    localparam logic [11:0] V_SYNC_START  = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] V_SYNC_STOP   = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic [11:0] h_next_ext;
    logic [11:0] v_next_ext;
    logic        line_end;
    logic        frame_end;
    logic        hsync_next;
    logic        vsync_next;
    logic        hblnk_next;
    logic        vblnk_next;

    // -------------------------------------------------------------------------
    // Counter advance
    //
    // The horizontal counter steps every cycle and wraps after H_LAST. The
    // vertical counter steps only on the cycle the horizontal counter wraps.
    // Any out-of-range value (which normal operation never produces) is
    // forced back to 0 on the next edge instead of running on to overflow.
    // An out-of-range hcount does not count as a line end, so it cannot
    // advance vcount by itself.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        line_end  = (hcount_out == H_LAST);
        frame_end = line_end && (vcount_out == V_LAST);

        h_next = hcount_out + 11'd1;
        if (hcount_out >= H_LAST) begin
            h_next = '0;
        end

        v_next = vcount_out;
        if (vcount_out > V_LAST) begin
            v_next = '0;
        end else if (line_end) begin
            v_next = (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Flag decode from the next counter values, so the registered flags line
    // up with the registered counters. vsync/vblnk depend only on v_next, which
    // changes only at a line wrap, so they can only toggle at a line wrap too.
    // -------------------------------------------------------------------------
    always_comb begin
        h_next_ext = {1'b0, h_next};
        v_next_ext = {1'b0, v_next};

        hblnk_next = (h_next_ext >= H_BLANK_START);
        hsync_next = (h_next_ext >= H_SYNC_START) && (h_next_ext < H_SYNC_STOP);
        vblnk_next = (v_next_ext >= V_BLANK_START);
        vsync_next = (v_next_ext >= V_SYNC_START) && (v_next_ext < V_SYNC_STOP);
    end

    // -------------------------------------------------------------------------
    // Output registers
    //
    // Reset is synchronous and wins over everything: asserting rst mid-frame
    // zeroes the raster on the very next edge with no attempt to finish the
    // current line. The first edge after release then advances hcount to 1.
    // -------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge; blocking ones here would create order-
        // dependent simulation races between the counters and the flags.
        if (rst) begin
            hcount_out  <= '0;
            vcount_out  <= '0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount_out  <= h_next;
            vcount_out  <= v_next;
            hsync_out   <= hsync_next;
            vsync_out   <= vsync_next;
            hblnk_out   <= hblnk_next;
            vblnk_out   <= vblnk_next;
            frame_start <= frame_end;
        end
    end

endmodule
